// File: rtl/async_pulse_transmit.sv
// Sending side of the four-phase REQ/ACK bridge: one handshake per event,
// with saturating replay of events that arrive mid-handshake.
module async_pulse_transmit #(
    parameter int MIN_HIGH       = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int PEND_W         = 3
) (
    input  logic SYNC_CLK_IN,
    input  logic RESET_N_IN,
    input  logic PULSE_IN,
    input  logic ACK_IN,
    output logic REQ_OUT,
    output logic BUSY_OUT,
    output logic DONE_OUT,
    output logic DROP_OUT,
    output logic TIMEOUT_OUT
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [7:0]        HOLD_LAST = 8'(MIN_HIGH - 1);
    localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              ack_m, ack_s;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [7:0]        hold_q, hold_d;
    logic [15:0]       tmo_q, tmo_d;
    logic              abort_q, abort_d;
    logic              req_d, done_d, drop_d, tmo_p_d;

    always_ff @(posedge SYNC_CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ACK_IN;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge SYNC_CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            hold_q      <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
            REQ_OUT     <= 1'b0;
            DONE_OUT    <= 1'b0;
            DROP_OUT    <= 1'b0;
            TIMEOUT_OUT <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            abort_q     <= abort_d;
            REQ_OUT     <= req_d;
            DONE_OUT    <= done_d;
            DROP_OUT    <= drop_d;
            TIMEOUT_OUT <= tmo_p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        tmo_p_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PULSE_IN || pend_q != '0) begin
                    state_d = REQ_HIGH;
                    hold_d  = '0;
                    tmo_d   = '0;
                    abort_d = 1'b0;
                    if (!PULSE_IN) pend_d = pend_q - 1'b1;
                end
            end
            REQ_HIGH: begin
                if (hold_q != 8'hff) hold_d = hold_q + 8'd1;
                if (tmo_q != 16'hffff) tmo_d = tmo_q + 16'd1;
                if (ack_s && hold_q >= HOLD_LAST) begin
                    state_d = WAIT_LOW;
                end else if (!ack_s && tmo_q >= TO_LAST) begin
                    state_d = WAIT_LOW;
                    abort_d = 1'b1;
                    tmo_p_d = 1'b1;
                end
            end
            WAIT_LOW: begin
                // never leave while the far side still holds ACK
                if (!ack_s) begin
                    state_d = IDLE;
                    done_d  = !abort_q;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && PULSE_IN) begin
            if (pend_q != PEND_MAX) pend_d = pend_q + 1'b1;
            else drop_d = 1'b1;
        end
        req_d = (state_d == REQ_HIGH);
    end

    assign BUSY_OUT = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_async_pulse_transmit.sv
// Directed bench for async_pulse_transmit: vector table for single and
// replayed handshakes, hand sequences for burst, timeout, stuck ACK, reset.
module tb_async_pulse_transmit;

    localparam int SILENT = 0;
    localparam int AUTO   = 1;
    localparam int STUCK  = 2;
    localparam int TABLE  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic pulse;
    logic ack;
    logic req, busy, done, drop, tmo;

    int   mode = SILENT;
    logic tbl_ack = 1'b0;
    logic ack_model = 1'b0;
    int   hi_n = 0;
    int   lo_n = 0;

    int   total = 0;
    int   bad = 0;

    int   n_rise = 0, n_hi = 0, n_done = 0, n_drop = 0, n_tmo = 0;
    logic req_prev = 1'b0;

    typedef struct {
        logic pulse;
        logic ack;
        logic req;
        logic busy;
        logic done;
    } vec_t;

    vec_t tv[25];

    async_pulse_transmit #(
        .MIN_HIGH(4),
        .TIMEOUT_CYCLES(16),
        .PEND_W(2)
    ) dut (
        .SYNC_CLK_IN(clk),
        .RESET_N_IN(rst_n),
        .PULSE_IN(pulse),
        .ACK_IN(ack),
        .REQ_OUT(req),
        .BUSY_OUT(busy),
        .DONE_OUT(done),
        .DROP_OUT(drop),
        .TIMEOUT_OUT(tmo)
    );

    always #5 clk = ~clk;

    // receiver: ACK rises 3 cycles after REQ, falls 3 cycles after REQ drops
    always @(negedge clk) begin
        if (req) begin
            lo_n = 0;
            if (!ack_model) begin
                hi_n = hi_n + 1;
                if (hi_n == 3) ack_model = 1'b1;
            end
        end else begin
            hi_n = 0;
            if (ack_model) begin
                lo_n = lo_n + 1;
                if (lo_n == 3) ack_model = 1'b0;
            end
        end
    end

    always_comb begin
        ack = 1'b0;
        case (mode)
            AUTO:    ack = ack_model;
            STUCK:   ack = 1'b1;
            TABLE:   ack = tbl_ack;
            default: ack = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (req && !req_prev) n_rise = n_rise + 1;
        if (req) n_hi = n_hi + 1;
        if (done) n_done = n_done + 1;
        if (drop) n_drop = n_drop + 1;
        if (tmo) n_tmo = n_tmo + 1;
        req_prev = req;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int i;
        for (i = 0; i < maxc; i++) begin
            if (!busy) break;
            cyc(1);
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s: still busy after %0d cycles", nm, maxc);
        end
    endtask

    task automatic pulse1();
        pulse = 1'b1;
        cyc(1);
        pulse = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_rise, b_hi, b_done, b_drop, b_tmo;
        int i;
        int errs;
        logic seen;

        tv[0]  = '{1, 0, 1, 1, 0};
        tv[1]  = '{0, 0, 1, 1, 0};
        tv[2]  = '{0, 1, 1, 1, 0};
        tv[3]  = '{0, 1, 1, 1, 0};
        tv[4]  = '{0, 1, 0, 1, 0};
        tv[5]  = '{0, 0, 0, 1, 0};
        tv[6]  = '{0, 0, 0, 1, 0};
        tv[7]  = '{0, 0, 0, 0, 1};
        tv[8]  = '{0, 0, 0, 0, 0};
        tv[9]  = '{1, 0, 1, 1, 0};
        tv[10] = '{1, 0, 1, 1, 0};
        tv[11] = '{0, 1, 1, 1, 0};
        tv[12] = '{0, 1, 1, 1, 0};
        tv[13] = '{0, 1, 0, 1, 0};
        tv[14] = '{0, 0, 0, 1, 0};
        tv[15] = '{0, 0, 0, 1, 0};
        tv[16] = '{0, 0, 0, 1, 1};
        tv[17] = '{0, 0, 1, 1, 0};
        tv[18] = '{0, 0, 1, 1, 0};
        tv[19] = '{0, 1, 1, 1, 0};
        tv[20] = '{0, 1, 1, 1, 0};
        tv[21] = '{0, 1, 0, 1, 0};
        tv[22] = '{0, 0, 0, 1, 0};
        tv[23] = '{0, 0, 0, 1, 0};
        tv[24] = '{0, 0, 0, 0, 1};

        rst_n = 1'b0;
        pulse = 1'b0;
        cyc(3);
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_drop", drop, 0);
        check("rst_tmo", tmo, 0);
        rst_n = 1'b1;
        cyc(2);

        mode = TABLE;
        for (i = 0; i < 25; i++) begin
            pulse = tv[i].pulse;
            tbl_ack = tv[i].ack;
            cyc(1);
            check($sformatf("v%0d_req", i), req, tv[i].req);
            check($sformatf("v%0d_busy", i), busy, tv[i].busy);
            check($sformatf("v%0d_done", i), done, tv[i].done);
        end
        pulse = 1'b0;
        tbl_ack = 1'b0;
        check("tbl_drop", n_drop, 0);

        // burst of five pulses into a 2-bit pending counter
        mode = AUTO;
        cyc(5);
        b_rise = n_rise; b_done = n_done; b_drop = n_drop; b_tmo = n_tmo;
        for (i = 0; i < 5; i++) pulse1();
        wait_idle(300, "burst_idle");
        cyc(5);
        check("burst_req", n_rise - b_rise, 4);
        check("burst_done", n_done - b_done, 4);
        check("burst_drop", n_drop - b_drop, 1);
        check("burst_tmo", n_tmo - b_tmo, 0);

        // unresponsive receiver
        mode = SILENT;
        b_rise = n_rise; b_hi = n_hi; b_done = n_done; b_tmo = n_tmo;
        pulse1();
        wait_idle(100, "tmo_idle");
        cyc(10);
        check("tmo_hi_cycles", n_hi - b_hi, 16);
        check("tmo_pulses", n_tmo - b_tmo, 1);
        check("tmo_done", n_done - b_done, 0);
        check("tmo_req_low", req, 0);
        check("tmo_rises", n_rise - b_rise, 1);
        cyc(5);

        // pending=1 in IDLE coinciding with a new pulse
        mode = AUTO;
        b_rise = n_rise; b_done = n_done;
        pulse1();
        pulse1();
        seen = 1'b0;
        for (i = 0; i < 100; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        check("sim_first_done", seen, 1);
        check("sim_pend_before", dut.pend_q, 1);
        pulse1();
        check("sim_req", req, 1);
        check("sim_pend_after", dut.pend_q, 1);
        wait_idle(200, "sim_idle");
        cyc(5);
        check("sim_rises", n_rise - b_rise, 3);
        check("sim_done", n_done - b_done, 3);

        // ACK stuck high after REQ falls, one event pending
        b_rise = n_rise;
        pulse1();
        pulse1();
        seen = 1'b0;
        for (i = 0; i < 50; i++) begin
            if (n_rise != b_rise && !req) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        check("stuck_fall", seen, 1);
        mode = STUCK;
        errs = 0;
        for (i = 0; i < 20; i++) begin
            cyc(1);
            if (req !== 1'b0 || busy !== 1'b1) errs++;
        end
        check("stuck_hold", errs, 0);
        mode = SILENT;
        cyc(3);
        check("release_req_e3", req, 0);
        cyc(1);
        check("release_req_e4", req, 1);
        wait_idle(100, "stuck_idle");
        cyc(6);

        // async reset mid-REQ_HIGH with an event pending
        b_rise = n_rise; b_done = n_done; b_tmo = n_tmo;
        pulse1();
        pulse1();
        cyc(2);
        check("rst_mid_req", req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", req, 0);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc(30);
        check("rst_no_done", n_done - b_done, 0);
        check("rst_no_tmo", n_tmo - b_tmo, 0);
        check("rst_rises", n_rise - b_rise, 1);
        check("rst_req_low", req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/async_pulse_transmit.md
# async_pulse_transmit

Sending end of the single-wire request/acknowledge bridge between the CPLD clock domain and an unrelated far-side domain. Each one-cycle event pulse in the SYNC_CLK_IN domain becomes one full four-phase handshake on REQ_OUT/ACK_IN. The far-side receiver detects REQ_OUT with its own synchronizer and rising-edge detector. Events that arrive while a handshake is in flight are counted and replayed, up to a saturating limit. Overflow and unresponsive-receiver conditions are flagged.

## Interface
- MIN_HIGH, default 4: minimum number of cycles REQ_OUT stays high, range 2..255.
- TIMEOUT_CYCLES, default 1024: cycles in REQ_HIGH without a synchronized ACK before abort, range 8..65535.
- PEND_W, default 3: width of the pending-event counter; it saturates at 2^PEND_W-1.
- SYNC_CLK_IN  in  1  sole clock, rising edge.
- RESET_N_IN  in  1  asynchronous, active-low reset.
- PULSE_IN  in  1  one-cycle event strobe, synchronous to SYNC_CLK_IN.
- ACK_IN  in  1  acknowledge from the far domain, asynchronous; passes through an internal 2-flop synchronizer, ack_s.
- REQ_OUT  out  1  request level to the far domain, driven directly by a flop.
- BUSY_OUT  out  1  high when state≠IDLE or pending≠0.
- DONE_OUT  out  1  one-cycle pulse when a handshake completes normally.
- DROP_OUT  out  1  one-cycle pulse when an event is lost because pending is saturated.
- TIMEOUT_OUT  out  1  one-cycle pulse when a REQ_HIGH is aborted.

## Operation
- Reset values: state=IDLE; REQ_OUT, DONE_OUT, DROP_OUT and TIMEOUT_OUT = 0; pending=0; hold/timeout counters=0; synchronizer flops=0. Reset asserted mid-handshake drops REQ_OUT immediately, asynchronously, and discards all pending events.
- States:
  - IDLE → REQ_HIGH when PULSE_IN=1 or pending≠0. REQ_OUT goes high at the next edge and both counters clear.
  - REQ_HIGH → WAIT_LOW when ack_s=1 and hold count ≥ MIN_HIGH-1. REQ_OUT goes low.
  - REQ_HIGH → WAIT_LOW when the timeout count reaches TIMEOUT_CYCLES-1 with ack_s=0. REQ_OUT goes low and TIMEOUT_OUT pulses.
  - WAIT_LOW → IDLE when ack_s=0. DONE_OUT pulses only if this handshake was not aborted. WAIT_LOW has no timeout: a new REQ is never raised while ack_s=1.
- Pending accounting, evaluated every cycle:
  - IDLE start caused by PULSE_IN: that event is consumed directly and pending is unchanged.
  - IDLE start with PULSE_IN=0 and pending≠0: pending decrements by 1.
  - PULSE_IN=1 in any non-IDLE state: pending increments if below the maximum. At the maximum, pending holds and DROP_OUT pulses on the next edge.
- Counters:
  - Hold counter is 8 bits, saturating.
  - Timeout counter is 16 bits, saturating.
  - Both clear on entry to REQ_HIGH.
- BUSY_OUT is decoded from registered state and pending only, with no combinational path from PULSE_IN or ACK_IN.

## Timing
- PULSE_IN high in IDLE during cycle n → REQ_OUT=1 from edge n+1.
- ACK_IN rising before edge k → ack_s=1 after edge k+1. Falling edges have the same 2-edge latency.
- REQ_OUT high time = max(MIN_HIGH, ack latency+1) cycles.
- REQ_OUT low time between consecutive handshakes: at least 2 cycles (WAIT_LOW exit plus one IDLE cycle).
- DONE_OUT and TIMEOUT_OUT are registered and assert at the edge that performs the corresponding transition.
- A back-to-back replay from pending starts from IDLE one cycle after DONE_OUT.

## Test plan
1. Single event with MIN_HIGH=4 and a receiver model that raises ACK 3 cycles after REQ and drops it 3 cycles after REQ falls. PULSE_IN at cycle 10 → REQ_OUT high cycles 11–16; DONE_OUT once; BUSY_OUT low afterwards; pending stays 0.
2. Burst with PEND_W=2. Five PULSE_IN one cycle apart while the first handshake is active → pending reaches 3, DROP_OUT pulses once, exactly four REQ_OUT high periods total, DONE_OUT 4 times.
3. Timeout with TIMEOUT_CYCLES=16 and ACK_IN held 0 → REQ_OUT high exactly 16 cycles, TIMEOUT_OUT one pulse, no DONE_OUT, then REQ_OUT stays low until the next event.
4. Stuck ACK: ACK_IN forced 1 after REQ falls, with one event pending → REQ_OUT stays low and BUSY_OUT stays 1. Releasing ACK_IN → the replay REQ begins 4 cycles later (2 sync + WAIT_LOW→IDLE + IDLE→REQ_HIGH).
5. Simultaneous events: pending=1 in IDLE and PULSE_IN=1 in the same cycle → handshake starts, pending stays 1, two handshakes total.
6. Reset mid-REQ_HIGH: RESET_N_IN low asynchronously → REQ_OUT=0 without waiting for a clock edge, pending=0; no DONE_OUT or TIMEOUT_OUT after release.
